// File: rtl/bvh_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bvh_fetch_responder_pkg
// Purpose  : Shared scene-memory types for the BVH fetch responder: packed
//            node/leaf/primitive layouts, default widths and FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package bvh_fetch_responder_pkg;

    // Axis-aligned bounding box of one primitive: six single-precision bounds.
    typedef struct packed {
        logic [31:0] min_x;
        logic [31:0] min_y;
        logic [31:0] min_z;
        logic [31:0] max_x;
        logic [31:0] max_y;
        logic [31:0] max_z;
    } Primitive_AABB;

    // Interior node header: child links plus flag bits.
    typedef struct packed {
        logic [15:0] left_child;
        logic [15:0] right_child;
        logic [31:0] flags;
    } BVH_Node;

    // Leaf descriptor: range of primitives covered by the leaf.
    typedef struct packed {
        logic [31:0] prim_start;
        logic [31:0] prim_count;
        logic [31:0] rsvd;
    } BVH_Leaf;

    // One ROM node word: node header followed by its two leaf descriptors.
    typedef struct packed {
        BVH_Node node;
        BVH_Leaf leaf_lo;
        BVH_Leaf leaf_hi;
    } BVH_NodeWord;

    localparam int BVH_NODE_INDEX_WIDTH = 8;
    localparam int PRIM_INDEX_WIDTH     = 10;
    localparam int AABB_TEST_UNIT_SIZE  = 4;
    localparam int BVH_NODE_PACK_W      = $bits(BVH_NodeWord);
    localparam int PRIM_AABB_PACK_W     = $bits(Primitive_AABB);
    localparam int SCENE_MEM_LAT        = 2;
    localparam int PRIM_BASE_ADDR       = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_NODE_RD   = 3'd1,
        ST_NODE_WAIT = 3'd2,
        ST_PRIM_RD   = 3'd3,
        ST_PRIM_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } fetch_state_e;

    // Width of a slot index; never below one bit so single-slot builds stay legal.
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bvh_fetch_responder_fetch_latency_tracker.sv
`default_nettype none
// ============================================================================
// Module   : fetch_latency_tracker
// Purpose  : Fixed-depth shift register of {valid, slot tag} that marks when
//            a ROM read issued DEPTH cycles earlier is returning its data.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_latency_tracker #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             ret_valid_o,
    output logic [TAG_W-1:0] ret_tag_o
);

    logic             vld_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    // Shift every strobe down the pipe; reset drops all in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                vld_q[s] <= 1'b0;
                tag_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= push_i;
            tag_q[0] <= tag_i;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign ret_valid_o = vld_q[DEPTH-1];
    assign ret_tag_o   = tag_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bvh_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : bvh_fetch_responder
// Purpose  : Serves node and primitive fetches from one ray core out of the
//            scene ROM; one request outstanding, response held until taken.
// Revision : 1.0 - initial release
// ============================================================================
module bvh_fetch_responder
    import bvh_fetch_responder_pkg::*;
#(
    parameter  int NODE_IDX_W = BVH_NODE_INDEX_WIDTH,
    parameter  int PRIM_IDX_W = PRIM_INDEX_WIDTH,
    parameter  int UNIT_SIZE  = AABB_TEST_UNIT_SIZE,
    parameter  int NODE_W     = BVH_NODE_PACK_W,
    parameter  int PRIM_W     = PRIM_AABB_PACK_W,
    parameter  int MEM_LAT    = SCENE_MEM_LAT,
    parameter  int PRIM_BASE  = PRIM_BASE_ADDR,
    localparam int ADDR_W     = ((NODE_IDX_W > PRIM_IDX_W) ? NODE_IDX_W : PRIM_IDX_W) + 1,
    localparam int MEM_W      = (NODE_W > PRIM_W) ? NODE_W : PRIM_W,
    localparam int CNT_W      = $clog2(UNIT_SIZE) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      node_req_valid,
    input  logic [NODE_IDX_W-1:0]     node_req_index,
    output logic                      node_req_ready,
    input  logic                      prim_req_valid,
    input  logic [PRIM_IDX_W-1:0]     prim_req_start,
    input  logic [CNT_W-1:0]          prim_req_count,
    output logic                      prim_req_ready,
    output logic                      node_rsp_valid,
    output logic [NODE_W-1:0]         node_rsp_data,
    input  logic                      node_rsp_ready,
    output logic                      prim_rsp_valid,
    output logic [UNIT_SIZE*PRIM_W-1:0] prim_rsp_data,
    output logic [UNIT_SIZE-1:0]      prim_rsp_mask,
    input  logic                      prim_rsp_ready,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [MEM_W-1:0]          mem_rd_data
);

    localparam int SLOT_W = slot_width(UNIT_SIZE);

    fetch_state_e               state_q, state_d;
    logic [ADDR_W-1:0]          idx_q;        // node index or primitive start
    logic [CNT_W-1:0]           n_q;          // clamped primitive count
    logic [SLOT_W-1:0]          k_q;          // next primitive slot to read
    logic                       is_node_q;    // current transaction is a node fetch
    logic [NODE_W-1:0]          node_data_q;
    logic [UNIT_SIZE*PRIM_W-1:0] prim_data_q;
    logic [UNIT_SIZE-1:0]       prim_mask_q;

    logic                       accept_node;
    logic                       accept_prim;
    logic                       ret_valid;
    logic [SLOT_W-1:0]          ret_slot;
    logic [CNT_W-1:0]           req_cnt_clamped;
    logic [CNT_W-1:0]           last_slot;
    logic [ADDR_W-1:0]          prim_addr;

    // Requests beyond the unit size are served as a full unit.
    assign req_cnt_clamped = (prim_req_count > CNT_W'(UNIT_SIZE)) ? CNT_W'(UNIT_SIZE)
                                                                  : prim_req_count;
    assign last_slot = n_q - CNT_W'(1);
    assign prim_addr = ADDR_W'(PRIM_BASE) + idx_q + ADDR_W'(k_q);

    fetch_latency_tracker #(
        .DEPTH (MEM_LAT),
        .TAG_W (SLOT_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .push_i      (mem_rd_en),
        .tag_i       (k_q),
        .ret_valid_o (ret_valid),
        .ret_tag_o   (ret_slot)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, request handshakes, ROM strobes and response valids.
    always_comb begin
        state_d        = state_q;
        node_req_ready = 1'b0;
        prim_req_ready = 1'b0;
        node_rsp_valid = 1'b0;
        prim_rsp_valid = 1'b0;
        mem_rd_en      = 1'b0;
        mem_rd_addr    = '0;
        accept_node    = 1'b0;
        accept_prim    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                node_req_ready = 1'b1;
                // Node fetches have priority; hold off primitives when both ask.
                prim_req_ready = !node_req_valid;
                if (node_req_valid) begin
                    accept_node = 1'b1;
                    state_d     = ST_NODE_RD;
                end else if (prim_req_valid) begin
                    accept_prim = 1'b1;
                    state_d     = (prim_req_count == '0) ? ST_RESP : ST_PRIM_RD;
                end
            end
            ST_NODE_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = idx_q;
                state_d     = ST_NODE_WAIT;
            end
            ST_NODE_WAIT: begin
                if (ret_valid) begin
                    state_d = ST_RESP;
                end
            end
            ST_PRIM_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = prim_addr;
                if (CNT_W'(k_q) == last_slot) begin
                    state_d = ST_PRIM_WAIT;
                end
            end
            ST_PRIM_WAIT: begin
                if (ret_valid && (CNT_W'(ret_slot) == last_slot)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                node_rsp_valid = is_node_q;
                prim_rsp_valid = !is_node_q;
                if (is_node_q ? node_rsp_ready : prim_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Keep every output quiet while reset is held.
        if (reset) begin
            node_req_ready = 1'b0;
            prim_req_ready = 1'b0;
            node_rsp_valid = 1'b0;
            prim_rsp_valid = 1'b0;
            mem_rd_en      = 1'b0;
            mem_rd_addr    = '0;
            accept_node    = 1'b0;
            accept_prim    = 1'b0;
        end
    end

    // Latch request fields, step the slot counter and capture returning ROM words.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            is_node_q   <= 1'b0;
            node_data_q <= '0;
            prim_data_q <= '0;
            prim_mask_q <= '0;
        end else begin
            if (accept_node) begin
                idx_q     <= ADDR_W'(node_req_index);
                is_node_q <= 1'b1;
                k_q       <= '0;
            end else if (accept_prim) begin
                idx_q       <= ADDR_W'(prim_req_start);
                is_node_q   <= 1'b0;
                n_q         <= req_cnt_clamped;
                k_q         <= '0;
                // Slots that are never read must read back as zero.
                prim_data_q <= '0;
                prim_mask_q <= '0;
            end else if (state_q == ST_PRIM_RD) begin
                k_q <= k_q + SLOT_W'(1);
            end

            if (ret_valid) begin
                if (is_node_q) begin
                    node_data_q <= mem_rd_data[NODE_W-1:0];
                end else begin
                    prim_data_q[int'(ret_slot)*PRIM_W +: PRIM_W] <= mem_rd_data[PRIM_W-1:0];
                    prim_mask_q[ret_slot] <= 1'b1;
                end
            end
        end
    end

    assign node_rsp_data = node_data_q;
    assign prim_rsp_data = prim_data_q;
    assign prim_rsp_mask = prim_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_bvh_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bvh_fetch_responder
// Purpose  : Directed self-checking bench for bvh_fetch_responder with a
//            two-cycle scene ROM model, ROM[a] = a * 0x01010101.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bvh_fetch_responder;

    localparam int NODE_W = 256;
    localparam int PRIM_W = 192;
    localparam int UNIT   = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   node_req_valid;
    logic [7:0]             node_req_index;
    logic                   node_req_ready;
    logic                   prim_req_valid;
    logic [9:0]             prim_req_start;
    logic [2:0]             prim_req_count;
    logic                   prim_req_ready;
    logic                   node_rsp_valid;
    logic [NODE_W-1:0]      node_rsp_data;
    logic                   node_rsp_ready;
    logic                   prim_rsp_valid;
    logic [UNIT*PRIM_W-1:0] prim_rsp_data;
    logic [UNIT-1:0]        prim_rsp_mask;
    logic                   prim_rsp_ready;
    logic                   mem_rd_en;
    logic [10:0]            mem_rd_addr;
    logic [255:0]           mem_rd_data;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int node_hs = 0;
    int prim_hs = 0;
    logic [10:0] rd_addr_q [$];
    int          rd_cyc_q  [$];
    logic [255:0] pipe [2];

    always #5 clk = ~clk;

    bvh_fetch_responder dut (
        .clk            (clk),
        .reset          (reset),
        .node_req_valid (node_req_valid),
        .node_req_index (node_req_index),
        .node_req_ready (node_req_ready),
        .prim_req_valid (prim_req_valid),
        .prim_req_start (prim_req_start),
        .prim_req_count (prim_req_count),
        .prim_req_ready (prim_req_ready),
        .node_rsp_valid (node_rsp_valid),
        .node_rsp_data  (node_rsp_data),
        .node_rsp_ready (node_rsp_ready),
        .prim_rsp_valid (prim_rsp_valid),
        .prim_rsp_data  (prim_rsp_data),
        .prim_rsp_mask  (prim_rsp_mask),
        .prim_rsp_ready (prim_rsp_ready),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data)
    );

    function automatic logic [255:0] rom(input int a);
        return {192'b0, 64'(a) * 64'h0101_0101};
    endfunction

    function automatic logic [191:0] prim_word(input int a);
        logic [255:0] t;
        t = rom(a);
        return t[191:0];
    endfunction

    // ROM model: two-stage read pipe; filler pattern when no read was issued.
    always @(posedge clk) begin
        pipe[0] <= mem_rd_en ? rom(int'(mem_rd_addr)) : {8{32'hDEAD_BEEF}};
        pipe[1] <= pipe[0];
    end
    assign mem_rd_data = pipe[1];

    // Cycle counter, handshake counters and ROM read log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (node_rsp_valid && node_rsp_ready) node_hs <= node_hs + 1;
        if (prim_rsp_valid && prim_rsp_ready) prim_hs <= prim_hs + 1;
        if (mem_rd_en) begin
            rd_addr_q.push_back(mem_rd_addr);
            rd_cyc_q.push_back(cyc);
        end
    end

    task automatic check_value(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_node(input int idx);
        @(negedge clk);
        node_req_valid = 1'b1;
        node_req_index = 8'(idx);
        @(posedge clk);
        #1 node_req_valid = 1'b0;
    endtask

    task automatic send_prim(input int start, input int cnt);
        @(negedge clk);
        prim_req_valid = 1'b1;
        prim_req_start = 10'(start);
        prim_req_count = 3'(cnt);
        @(posedge clk);
        #1 prim_req_valid = 1'b0;
    endtask

    // Latency = edge (counted from the accepting edge) at which valid is first seen high.
    task automatic wait_rsp(input bit is_node, output int lat);
        lat = -1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (is_node ? node_rsp_valid : prim_rsp_valid) begin
                lat = j + 1;
                break;
            end
        end
        if (lat < 0) check_value("rsp_timeout", 0, 1);
    endtask

    function automatic logic [191:0] slot(input int k);
        return prim_rsp_data[k*PRIM_W +: PRIM_W];
    endfunction

    initial begin
        int lat;
        int base;
        int bad;
        int hs0;
        int seen;

        reset          = 1'b1;
        node_req_valid = 1'b0;
        node_req_index = '0;
        prim_req_valid = 1'b0;
        prim_req_start = '0;
        prim_req_count = '0;
        node_rsp_ready = 1'b1;
        prim_rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_outputs",
                    {node_req_ready, prim_req_ready, node_rsp_valid, prim_rsp_valid, mem_rd_en}, 0);
        check_value("rst_mask", prim_rsp_mask, 0);
        reset = 1'b0;
        @(negedge clk);
        check_value("idle_ready", {node_req_ready, prim_req_ready}, 2'b11);

        // 1: node fetch, index 5
        send_node(5);
        wait_rsp(1'b1, lat);
        check_value("t1_latency", lat, 4);
        check_value("t1_data", node_rsp_data, rom(5));
        check_value("t1_addr", rd_addr_q[rd_addr_q.size()-1], 5);
        hs0 = node_hs;
        @(negedge clk);
        check_value("t1_one_cycle", node_rsp_valid, 0);
        check_value("t1_handshakes", node_hs - hs0, 1);

        // 2: primitive fetch, start 10 count 3
        base = rd_addr_q.size();
        send_prim(10, 3);
        wait_rsp(1'b0, lat);
        check_value("t2_latency", lat, 6);
        check_value("t2_nreads", rd_addr_q.size() - base, 3);
        check_value("t2_addrs", {rd_addr_q[base], rd_addr_q[base+1], rd_addr_q[base+2]},
                    {11'd10, 11'd11, 11'd12});
        check_value("t2_consecutive", {rd_cyc_q[base+1] - rd_cyc_q[base], rd_cyc_q[base+2] - rd_cyc_q[base]},
                    {32'd1, 32'd2});
        check_value("t2_mask", prim_rsp_mask, 4'b0111);
        check_value("t2_slot0", slot(0), prim_word(10));
        check_value("t2_slot2", slot(2), prim_word(12));
        check_value("t2_slot3", slot(3), 0);
        @(negedge clk);
        check_value("t2_one_cycle", prim_rsp_valid, 0);

        // 3: node and primitive requested together
        @(negedge clk);
        node_req_valid = 1'b1;
        node_req_index = 8'd7;
        prim_req_valid = 1'b1;
        prim_req_start = 10'd20;
        prim_req_count = 3'd2;
        #1;
        check_value("t3_ready_arb", {node_req_ready, prim_req_ready}, 2'b10);
        @(posedge clk);
        #1 node_req_valid = 1'b0;
        seen = 0;
        lat  = -1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (prim_req_ready) seen++;
            if (node_rsp_valid) begin
                lat = j + 1;
                break;
            end
        end
        check_value("t3_node_latency", lat, 4);
        check_value("t3_node_data", node_rsp_data, rom(7));
        check_value("t3_prim_held_off", seen, 0);
        @(negedge clk);
        check_value("t3_prim_ready_after", prim_req_ready, 1);
        @(posedge clk);
        #1 prim_req_valid = 1'b0;
        wait_rsp(1'b0, lat);
        check_value("t3_prim_latency", lat, 5);
        check_value("t3_mask", prim_rsp_mask, 4'b0011);
        check_value("t3_slot1", slot(1), prim_word(21));
        check_value("t3_slot2", slot(2), 0);

        // 4: consumer back-pressure on a node response
        @(negedge clk);
        node_rsp_ready = 1'b0;
        send_node(9);
        wait_rsp(1'b1, lat);
        check_value("t4_latency", lat, 4);
        prim_req_valid = 1'b1;
        prim_req_start = 10'd50;
        prim_req_count = 3'd1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!node_rsp_valid || node_rsp_data !== rom(9) || node_req_ready || prim_req_ready) bad++;
        end
        check_value("t4_hold_stable", bad, 0);
        hs0 = node_hs;
        prim_req_valid = 1'b0;
        node_rsp_ready = 1'b1;
        @(negedge clk);
        check_value("t4_valid_drop", node_rsp_valid, 0);
        repeat (3) @(negedge clk);
        check_value("t4_one_handshake", node_hs - hs0, 1);
        check_value("t4_no_prim", prim_rsp_valid, 0);

        // 5: zero count, then clamped count
        base = rd_addr_q.size();
        send_prim(30, 0);
        wait_rsp(1'b0, lat);
        check_value("t5_zero_latency", lat, 1);
        check_value("t5_zero_mask", prim_rsp_mask, 0);
        check_value("t5_zero_data", |prim_rsp_data, 0);
        check_value("t5_zero_reads", rd_addr_q.size() - base, 0);
        base = rd_addr_q.size();
        send_prim(1022, 7);
        wait_rsp(1'b0, lat);
        check_value("t5_clamp_latency", lat, 7);
        check_value("t5_clamp_reads", rd_addr_q.size() - base, 4);
        check_value("t5_clamp_last_addr", rd_addr_q[rd_addr_q.size()-1], 1025);
        check_value("t5_clamp_mask", prim_rsp_mask, 4'b1111);
        check_value("t5_clamp_slot3", slot(3), prim_word(1025));

        // 6: reset during PRIM_WAIT
        send_prim(40, 4);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_value("t6_rst_outputs",
                    {node_req_ready, prim_req_ready, node_rsp_valid, prim_rsp_valid, mem_rd_en}, 0);
        check_value("t6_rst_mask", prim_rsp_mask, 0);
        reset = 1'b0;
        hs0  = prim_hs;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (prim_rsp_valid) seen++;
        end
        check_value("t6_no_response", seen, 0);
        check_value("t6_no_handshake", prim_hs - hs0, 0);
        check_value("t6_mask_clear", prim_rsp_mask, 0);
        send_node(3);
        wait_rsp(1'b1, lat);
        check_value("t6_after_latency", lat, 4);
        check_value("t6_after_data", node_rsp_data, rom(3));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
